// File: rtl/dff_share_pkg.sv
// Shared definitions for the round-robin shared-register arbiter: FSM encoding and index sizing.
package dff_share_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests/data in, ack and register state out.
interface dff_share_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OW = dff_share_pkg::idx_width(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] d_in;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic [OW-1:0]          owner;
    logic                   valid;

    modport master (output req, d_in, input ack, q, owner, valid);
    modport slave  (input req, d_in, output ack, q, owner, valid);

endinterface

// File: rtl/dff_en_reg.sv
// WIDTH-bit storage register with async active-low clear and synchronous load enable.
module dff_en_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter granting one-cycle write access to a single shared register;
// tracks the last writer and whether any write has landed since reset.
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    dff_share_arbiter_if.slave bus
);

    localparam int unsigned     OW   = idx_width(N_REQ);
    localparam logic [OW-1:0]   LAST = OW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [OW-1:0]    ptr;
    logic [OW-1:0]    gnt_idx;
    logic [OW-1:0]    win_idx;
    logic             win_found;
    logic             gnt_hit;
    logic             reg_en;
    logic [N_REQ-1:0] gnt_mask;
    logic [WIDTH-1:0] gnt_data;

    // First requester at or after ptr, wrapping explicitly so indices stay below N_REQ.
    always_comb begin : scan
        logic [N_REQ-1:0] sh;
        int unsigned      idx;
        win_found = 1'b0;
        win_idx   = '0;
        sh        = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sh = bus.req >> idx;
            if (!win_found && sh[0]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    assign gnt_mask = ONE << gnt_idx;
    assign gnt_hit  = (bus.req & gnt_mask) != '0;
    assign gnt_data = WIDTH'(bus.d_in >> (32'(gnt_idx) * WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus same-cycle ack/enable; a dropped request in GRANT aborts silently.
    always_comb begin
        state_nxt = state;
        reg_en    = 1'b0;
        bus.ack   = '0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_nxt = ST_IDLE;
                if (gnt_hit) begin
                    reg_en  = 1'b1;
                    bus.ack = gnt_mask;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_idx   <= '0;
            ptr       <= '0;
            bus.owner <= '0;
            bus.valid <= 1'b0;
        end else begin
            if (state == ST_IDLE && win_found) begin
                gnt_idx <= win_idx;
            end
            if (reg_en) begin
                ptr       <= (gnt_idx == LAST) ? '0 : gnt_idx + OW'(1);
                bus.owner <= gnt_idx;
                bus.valid <= 1'b1;
            end
        end
    end

    dff_en_reg #(.WIDTH(WIDTH)) u_store (
        .clk   (clk),
        .rst_n (reset),
        .en    (reg_en),
        .d     (gnt_data),
        .q     (bus.q)
    );

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Scoreboard bench for dff_share_arbiter: a 4-requester instance plus a 3-requester one for wrap.
module tb_dff_share_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) a4 ();
    dff_share_arbiter_if #(.N_REQ(3), .WIDTH(8)) b3 ();

    dff_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut4 (.clk(clk), .reset(reset), .bus(a4));
    dff_share_arbiter #(.N_REQ(3), .WIDTH(8)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mptr4  = 0;
    int   mptr3  = 0;

    function automatic int pick(input logic [7:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (p + k) % n;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] slice(input logic [31:0] d, input int i);
        logic [31:0] t;
        t = d >> (i * 8);
        return t[7:0];
    endfunction

    task automatic push_exp4();
        exp_t e;
        e.idx  = pick({4'b0, a4.req}, mptr4, 4);
        e.data = slice(a4.d_in, e.idx);
        sb.push_back(e);
    endtask

    task automatic push_exp3();
        exp_t e;
        e.idx  = pick({5'b0, b3.req}, mptr3, 3);
        e.data = slice({8'h0, b3.d_in}, e.idx);
        sb.push_back(e);
    endtask

    // Negedges without ack before the ack negedge; returns 6 on timeout.
    task automatic wait_ack4(output int w);
        w = 0;
        @(negedge clk);
        while (a4.ack == '0 && w < 6) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ack3(output int w);
        w = 0;
        @(negedge clk);
        while (b3.ack == '0 && w < 6) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset  = 1'b0;
        a4.req = '0;
        b3.req = '0;
        @(posedge clk); #1;
        reset  = 1'b1;
        mptr4  = 0;
        mptr3  = 0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        a4.req  = 4'b1111;
        a4.d_in = 32'hDEAD_BEEF;
        b3.req  = 3'b111;
        b3.d_in = 24'hC0FFEE;
        repeat (4) begin
            @(negedge clk);
            checks++; if (a4.ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", a4.ack); end
            checks++; if (a4.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", a4.q); end
            checks++; if (a4.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", a4.owner); end
            checks++; if (a4.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a4.valid); end
            checks++; if (b3.ack !== 3'b0) begin errors++; $display("FAIL reset_ack3 got %b want 000", b3.ack); end
        end
        @(posedge clk); #1;
        a4.req = '0;
        b3.req = '0;
        reset  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (a4.ack !== 4'b0) begin errors++; $display("FAIL idle_ack got %b want 0000", a4.ack); end
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   w;
        @(posedge clk); #1;
        a4.d_in = {8'h44, 8'hA5, 8'h22, 8'h11};
        a4.req  = 4'b0100;
        push_exp4();
        wait_ack4(w);
        e = sb.pop_front();
        checks++; if (a4.ack !== 4'(1 << e.idx) || w != 1) begin errors++; $display("FAIL single_ack got %b after %0d want %b after 1", a4.ack, w, 4'(1 << e.idx)); end
        @(posedge clk); #1;
        a4.req = '0;
        mptr4  = (e.idx + 1) % 4;
        @(negedge clk);
        checks++; if (a4.q !== e.data) begin errors++; $display("FAIL single_q got %h want %h", a4.q, e.data); end
        checks++; if (a4.owner !== 2'(e.idx)) begin errors++; $display("FAIL single_owner got %0d want %0d", a4.owner, e.idx); end
        checks++; if (a4.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", a4.valid); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   w;
        apply_reset();
        a4.d_in = {8'h44, 8'h33, 8'h22, 8'h11};
        a4.req  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            push_exp4();
            wait_ack4(w);
            e = sb.pop_front();
            checks++; if (a4.ack !== 4'(1 << e.idx) || w != ((g == 0) ? 1 : 0)) begin errors++; $display("FAIL rr_ack[%0d] got %b after %0d want %b", g, a4.ack, w, 4'(1 << e.idx)); end
            mptr4 = (e.idx + 1) % 4;
            @(negedge clk);
            checks++; if (a4.q !== e.data || a4.owner !== 2'(e.idx)) begin errors++; $display("FAIL rr_q[%0d] got %h/%0d want %h/%0d", g, a4.q, a4.owner, e.data, e.idx); end
            checks++; if (a4.ack !== 4'b0) begin errors++; $display("FAIL rr_gap[%0d] got %b want 0000", g, a4.ack); end
        end
        @(posedge clk); #1;
        a4.req = '0;
    endtask

    task automatic test_abort();
        exp_t e;
        int   w;
        apply_reset();
        a4.d_in = {8'h44, 8'h33, 8'h5A, 8'h3C};
        a4.req  = 4'b0010;
        @(posedge clk); #1;
        a4.req = '0;
        @(negedge clk);
        checks++; if (a4.ack !== 4'b0) begin errors++; $display("FAIL abort_ack got %b want 0000", a4.ack); end
        @(negedge clk);
        checks++; if (a4.q !== 8'h00 || a4.owner !== 2'd0 || a4.valid !== 1'b0) begin errors++; $display("FAIL abort_state got q=%h owner=%0d valid=%b want 00/0/0", a4.q, a4.owner, a4.valid); end
        @(posedge clk); #1;
        a4.req = 4'b0011;
        push_exp4();
        wait_ack4(w);
        e = sb.pop_front();
        checks++; if (a4.ack !== 4'(1 << e.idx) || w != 1) begin errors++; $display("FAIL abort_next_ack got %b want %b", a4.ack, 4'(1 << e.idx)); end
        @(posedge clk); #1;
        a4.req = '0;
        mptr4  = (e.idx + 1) % 4;
        @(negedge clk);
        checks++; if (a4.q !== e.data || a4.valid !== 1'b1) begin errors++; $display("FAIL abort_next_q got %h/%b want %h/1", a4.q, a4.valid, e.data); end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   w;
        @(posedge clk); #1;
        a4.d_in = {8'h99, 8'h33, 8'h22, 8'h77};
        a4.req  = 4'b1000;
        push_exp4();
        wait_ack4(w);
        e = sb.pop_front();
        checks++; if (a4.ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL midrst_grant got %b want %b", a4.ack, 4'(1 << e.idx)); end
        #1 reset = 1'b0;
        #1;
        checks++; if (a4.ack !== 4'b0) begin errors++; $display("FAIL midrst_ack got %b want 0000", a4.ack); end
        checks++; if (a4.q !== 8'h00 || a4.owner !== 2'd0 || a4.valid !== 1'b0) begin errors++; $display("FAIL midrst_state got q=%h owner=%0d valid=%b want 00/0/0", a4.q, a4.owner, a4.valid); end
        @(posedge clk); #1;
        a4.req = '0;
        reset  = 1'b1;
        mptr4  = 0;
        mptr3  = 0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (a4.ack !== 4'b0) begin errors++; $display("FAIL midrst_release_ack got %b want 0000", a4.ack); end
        end
        @(posedge clk); #1;
        a4.req = 4'b1001;
        push_exp4();
        wait_ack4(w);
        e = sb.pop_front();
        checks++; if (a4.ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL midrst_ptr got %b want %b", a4.ack, 4'(1 << e.idx)); end
        @(posedge clk); #1;
        a4.req = '0;
        mptr4  = (e.idx + 1) % 4;
        @(negedge clk);
        checks++; if (a4.q !== e.data) begin errors++; $display("FAIL midrst_q got %h want %h", a4.q, e.data); end
    endtask

    task automatic test_wrap3();
        exp_t e;
        int   w;
        @(posedge clk); #1;
        b3.d_in = {8'hC3, 8'hB2, 8'hA1};
        b3.req  = 3'b010;
        push_exp3();
        wait_ack3(w);
        e = sb.pop_front();
        checks++; if (b3.ack !== 3'(1 << e.idx)) begin errors++; $display("FAIL wrap_first got %b want %b", b3.ack, 3'(1 << e.idx)); end
        @(posedge clk); #1;
        b3.req = '0;
        mptr3  = (e.idx + 1) % 3;
        @(negedge clk);
        checks++; if (b3.q !== e.data || b3.owner !== 2'(e.idx)) begin errors++; $display("FAIL wrap_first_q got %h/%0d want %h/%0d", b3.q, b3.owner, e.data, e.idx); end
        @(posedge clk); #1;
        b3.req = 3'b101;
        for (int g = 0; g < 2; g++) begin
            push_exp3();
            wait_ack3(w);
            e = sb.pop_front();
            checks++; if (b3.ack !== 3'(1 << e.idx) || w > 1) begin errors++; $display("FAIL wrap_ack[%0d] got %b want %b", g, b3.ack, 3'(1 << e.idx)); end
            mptr3 = (e.idx + 1) % 3;
            if (g == 1) begin
                @(posedge clk); #1;
                b3.req = '0;
            end
            @(negedge clk);
            checks++; if (b3.q !== e.data || b3.owner !== 2'(e.idx)) begin errors++; $display("FAIL wrap_q[%0d] got %h/%0d want %h/%0d", g, b3.q, b3.owner, e.data, e.idx); end
        end
    endtask

    initial begin
        a4.req  = '0;
        a4.d_in = '0;
        b3.req  = '0;
        b3.d_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_mid_reset();
        test_wrap3();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
